// File: rtl/hamming_secded_decoder.sv
// Hamming(16,11) SECDED decoder stage.
// Walks NUM_MSG encoded words in data memory, corrects single-bit errors,
// flags double-bit errors and writes the 11-bit message plus a 2-bit status
// back to memory. Owns the single memory port while busy.
module hamming_secded_decoder #(
   parameter int NUM_MSG  = 15,
   parameter int SRC_BASE = 30,
   parameter int DST_BASE = 0,
   parameter int AW       = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [7:0]    mem_rd_data,
   output logic [AW-1:0] mem_addr,
   output logic          mem_wr_en,
   output logic [7:0]    mem_wr_data,
   output logic          busy,
   output logic          done,
   output logic [3:0]    single_cnt,
   output logic [3:0]    double_cnt
);

   typedef enum logic [2:0] {
      IDLE, RD_LO, RD_HI, DECODE, WR_LO, WR_HI, DONE
   } state_t;

   state_t state, state_next;

   logic [AW-1:0] idx;
   logic [15:0]   word;
   logic [7:0]    out_lo, out_hi;
   logic [3:0]    syn;
   logic          par;
   logic [15:0]   fixed;
   logic [1:0]    flag;
   logic          accept;
   logic          last;
   logic [AW-1:0] offs, src_addr, dst_addr;

   // A start is only honoured while the block is not in the middle of a run.
   assign accept   = start && ((state == IDLE) || (state == DONE));
   assign last     = (idx == AW'(NUM_MSG - 1));
   assign offs     = {idx[AW-2:0], 1'b0};
   assign src_addr = AW'(SRC_BASE) + offs;
   assign dst_addr = AW'(DST_BASE) + offs;

   // Syndrome, overall parity, correction and status for the latched word.
   always_comb begin
      syn = '0;
      for (int k = 1; k < 16; k++) begin
         if (word[k]) syn = syn ^ 4'(k);
      end
      par   = ^word;
      fixed = word;
      if (par && (syn != 4'd0)) fixed[syn] = ~word[syn];
      if ((syn != 4'd0) && !par) flag = 2'b10;
      else if (par)              flag = 2'b01;
      else                       flag = 2'b00;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state sequencing: five steps per message, then DONE after the last.
   always_comb begin
      state_next = state;
      case (state)
         IDLE, DONE: if (start) state_next = RD_LO;
         RD_LO:      state_next = RD_HI;
         RD_HI:      state_next = DECODE;
         DECODE:     state_next = WR_LO;
         WR_LO:      state_next = WR_HI;
         WR_HI:      state_next = last ? DONE : RD_LO;
         default:    state_next = IDLE;
      endcase
   end

   // Memory port and busy are pure functions of the current state.
   always_comb begin
      mem_addr    = '0;
      mem_wr_en   = 1'b0;
      mem_wr_data = 8'h00;
      busy        = 1'b0;
      case (state)
         RD_LO:  begin busy = 1'b1; mem_addr = src_addr; end
         RD_HI:  begin busy = 1'b1; mem_addr = src_addr + AW'(1); end
         DECODE: busy = 1'b1;
         WR_LO:  begin
            busy = 1'b1; mem_addr = dst_addr; mem_wr_en = 1'b1; mem_wr_data = out_lo;
         end
         WR_HI:  begin
            busy = 1'b1; mem_addr = dst_addr + AW'(1); mem_wr_en = 1'b1; mem_wr_data = out_hi;
         end
         default: ;
      endcase
   end

   // Datapath: byte latches, decoded output bytes, message index, counters, done flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         idx        <= '0;
         word       <= '0;
         out_lo     <= '0;
         out_hi     <= '0;
         single_cnt <= '0;
         double_cnt <= '0;
         done       <= 1'b0;
      end else if (accept) begin
         idx        <= '0;
         single_cnt <= '0;
         double_cnt <= '0;
         done       <= 1'b0;
      end else begin
         case (state)
            RD_LO:  word[7:0]  <= mem_rd_data;
            RD_HI:  word[15:8] <= mem_rd_data;
            DECODE: begin
               out_lo <= {fixed[12], fixed[11], fixed[10], fixed[9],
                          fixed[7], fixed[6], fixed[5], fixed[3]};
               out_hi <= {flag, 3'b000, fixed[15], fixed[14], fixed[13]};
               if ((flag == 2'b01) && (single_cnt != 4'hF)) single_cnt <= single_cnt + 4'd1;
               if ((flag == 2'b10) && (double_cnt != 4'hF)) double_cnt <= double_cnt + 4'd1;
            end
            WR_HI:  if (!last) idx <= idx + AW'(1);
            DONE:   done <= 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Self-checking bench for hamming_secded_decoder: hand-picked words plus
// directed encoded messages with planned bit flips, done timing, ignored
// second start, mid-run reset and a clean rerun.
module tb_hamming_secded_decoder;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] mem_rd_data;
   logic [7:0] mem_addr;
   logic       mem_wr_en;
   logic [7:0] mem_wr_data;
   logic       busy;
   logic       done;
   logic [3:0] single_cnt;
   logic [3:0] double_cnt;

   logic [7:0]  mem [0:255];
   logic [15:0] srcWord [15];
   logic [15:0] expWord [15];
   int          expSingle;
   int          expDouble;
   int          checks = 0;
   int          errors = 0;
   int          badWrites = 0;
   int          doneCycle;

   localparam int DPOS [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
   localparam logic [10:0] MSGS [10] = '{11'h555, 11'h2AA, 11'h123, 11'h7FE, 11'h001,
                                         11'h400, 11'h3C3, 11'h0F0, 11'h6B5, 11'h1A2};
   localparam int NFLIP [10] = '{1, 1, 2, 1, 0, 1, 2, 1, 1, 2};
   localparam int POSA  [10] = '{5, 0, 3, 15, 0, 9, 0, 8, 11, 14};
   localparam int POSB  [10] = '{0, 0, 12, 0, 0, 0, 7, 0, 0, 15};

   hamming_secded_decoder dut (
      .clk(clk), .reset(reset), .start(start), .mem_rd_data(mem_rd_data),
      .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
      .busy(busy), .done(done), .single_cnt(single_cnt), .double_cnt(double_cnt)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Combinational read port of the data memory.
   assign mem_rd_data = mem[mem_addr];

   // Memory write on the rising edge.
   always @(posedge clk) begin
      if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
   end

   // Any write that lands outside the destination region is recorded.
   always @(negedge clk) begin
      if (mem_wr_en && (mem_addr >= 8'd30)) badWrites = badWrites + 1;
   end

   function automatic logic [15:0] encode(input logic [10:0] d);
      logic [15:0] w;
      logic [3:0]  s;
      w = '0;
      for (int j = 0; j < 11; j++) w[DPOS[j]] = d[j];
      s = '0;
      for (int k = 1; k < 16; k++) if (w[k]) s = s ^ 4'(k);
      w[1] = s[0];
      w[2] = s[1];
      w[4] = s[2];
      w[8] = s[3];
      w[0] = ^w[15:1];
      return w;
   endfunction

   function automatic logic [10:0] extract(input logic [15:0] w);
      logic [10:0] d;
      for (int j = 0; j < 11; j++) d[j] = w[DPOS[j]];
      return d;
   endfunction

   function automatic logic [15:0] pack(input logic [10:0] d, input logic [1:0] f);
      return {f, 3'b000, d[10:8], d[7:0]};
   endfunction

   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks = checks + 1;
      if (obs !== exp) begin
         errors = errors + 1;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Builds source words and expected output words, loads memory, poisons the destination.
   task automatic applyStimulus();
      logic [15:0] w;
      srcWord[0] = 16'h0000; expWord[0] = 16'h0000;
      srcWord[1] = 16'hFFFF; expWord[1] = 16'h07FF;
      srcWord[2] = 16'h0008; expWord[2] = 16'h4000;
      srcWord[3] = 16'h0001; expWord[3] = 16'h4000;
      srcWord[4] = 16'hFFF9; expWord[4] = 16'h87FF;
      expSingle = 2;
      expDouble = 1;
      for (int m = 0; m < 10; m++) begin
         w = encode(MSGS[m]);
         if (NFLIP[m] >= 1) w[POSA[m]] = ~w[POSA[m]];
         if (NFLIP[m] == 2) w[POSB[m]] = ~w[POSB[m]];
         srcWord[m+5] = w;
         if (NFLIP[m] == 0) expWord[m+5] = pack(MSGS[m], 2'b00);
         else if (NFLIP[m] == 1) begin
            expWord[m+5] = pack(MSGS[m], 2'b01);
            expSingle = expSingle + 1;
         end else begin
            expWord[m+5] = pack(extract(w), 2'b10);
            expDouble = expDouble + 1;
         end
      end
      for (int i = 0; i < 15; i++) begin
         mem[30 + 2*i]     = srcWord[i][7:0];
         mem[30 + 2*i + 1] = srcWord[i][15:8];
      end
      for (int a = 0; a < 30; a++) mem[a] = 8'hEE;
   endtask

   // Pulses start, re-pulses it mid-run, optionally resets at cycle resetAt, and times done.
   task automatic runOnce(input int resetAt, output int dc);
      dc = -1;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int n = 1; n <= 200; n++) begin
         @(posedge clk);
         #1;
         if (n == 1) begin
            checkOutput("busy_after_start", 16'(busy), 16'd1);
            checkOutput("done_cleared", 16'(done), 16'd0);
         end
         if (n == 10) start = 1'b1;
         if (n == 11) start = 1'b0;
         if (n == resetAt) reset = 1'b1;
         if ((resetAt > 0) && (n == resetAt + 1)) begin
            checkOutput("abort_done", 16'(done), 16'd0);
            checkOutput("abort_busy", 16'(busy), 16'd0);
            checkOutput("abort_wr_en", 16'(mem_wr_en), 16'd0);
            reset = 1'b0;
            break;
         end
         if (done) begin
            dc = n;
            break;
         end
      end
   endtask

   task automatic checkResults();
      for (int i = 0; i < 15; i++) begin
         checkOutput($sformatf("lo%0d", i), 16'(mem[2*i]), 16'(expWord[i][7:0]));
         checkOutput($sformatf("hi%0d", i), 16'(mem[2*i+1]), 16'(expWord[i][15:8]));
      end
      checkOutput("single_cnt", 16'(single_cnt), 16'(expSingle));
      checkOutput("double_cnt", 16'(double_cnt), 16'(expDouble));
      checkOutput("busy_at_done", 16'(busy), 16'd0);
   endtask

   initial begin
      for (int a = 0; a < 256; a++) mem[a] = 8'h00;
      reset = 1'b1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_busy", 16'(busy), 16'd0);
      checkOutput("rst_done", 16'(done), 16'd0);
      checkOutput("rst_wr_en", 16'(mem_wr_en), 16'd0);
      checkOutput("rst_addr", 16'(mem_addr), 16'd0);
      checkOutput("rst_wr_data", 16'(mem_wr_data), 16'd0);
      checkOutput("rst_counts", 16'({single_cnt, double_cnt}), 16'd0);
      reset = 1'b0;

      $display("[TB] run 1: full run with ignored second start");
      applyStimulus();
      runOnce(-1, doneCycle);
      checkOutput("done_cycle", 16'(doneCycle), 16'd76);
      checkResults();

      $display("[TB] run 2: reset asserted at cycle 20");
      applyStimulus();
      runOnce(20, doneCycle);
      checkOutput("abort_written", 16'(mem[6]), 16'(expWord[3][7:0]));
      checkOutput("abort_untouched", 16'(mem[8]), 16'h00EE);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("idle_after_abort", 16'(busy), 16'd0);

      $display("[TB] run 3: clean rerun after reset");
      applyStimulus();
      runOnce(-1, doneCycle);
      checkOutput("done_cycle_rerun", 16'(doneCycle), 16'd76);
      checkResults();

      checkOutput("stray_write", 16'(badWrites), 16'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hamming_secded_decoder.md
Name: hamming_secded_decoder

Overview:
- Hardware decoder stage directly downstream of the program-1 Hamming(16,11) SECDED encoder.
- Reads NUM_MSG encoded 16-bit words from data memory starting at SRC_BASE, little-endian byte pairs.
- For each word: corrects a single-bit error, flags a double-bit error, and writes the 11-bit message plus a 2-bit status back to memory at DST_BASE.
- Drives the single data-memory port directly while busy; the top level muxes the port to this block when busy=1.

Parameters:
- NUM_MSG, 15: number of encoded words processed per run.
- SRC_BASE, 30: byte address of word 0 low byte.
- DST_BASE, 0: byte address of decoded word 0 low byte.
- AW, 8: memory address width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run when idle.
- mem_rd_data  in  8  data memory read data; combinational read of mem_addr, same cycle.
- mem_addr  out  AW  data memory byte address.
- mem_wr_en  out  1  data memory write enable; write occurs on the clk edge.
- mem_wr_data  out  8  data memory write data.
- busy  out  1  high from the cycle after accepted start until DONE is entered.
- done  out  1  level; high in DONE, cleared by reset or an accepted start.
- single_cnt  out  4  count of words with a corrected single error this run.
- double_cnt  out  4  count of words with a detected double error this run.

Behaviour:
- Reset values: state=IDLE, msg index i=0, mem_addr=0, mem_wr_en=0, mem_wr_data=0, busy=0, done=0, counters=0.
- Encoded word layout, bit15..0: {d11..d5, p8, d4..d2, p4, d1, p2, p1, p0}.
  - Bit k (1..15) is Hamming position k; bit0 is overall parity p0.
- Syndrome s[3:0] = XOR of k over every set bit k in 1..15. Overall parity P = XOR of all 16 bits.
- Classification:
  - s=0, P=0: no error, F=00.
  - s≠0, P=1: single error; flip bit s before data extraction, F=01.
  - s=0, P=1: p0 error; data unchanged, F=01.
  - s≠0, P=0: double error; no correction, data extracted as-is, F=10.
- Output bytes:
  - Low byte = d8..d1.
  - High byte = {F[1:0], 3'b000, d11, d10, d9}.
- FSM per message, 5 cycles:
  - RD_LO: addr=SRC_BASE+2i; latch low byte.
  - RD_HI: addr=SRC_BASE+2i+1; latch high byte.
  - DECODE: compute syndrome, correction, flags; update counters.
  - WR_LO: addr=DST_BASE+2i, wr_en=1.
  - WR_HI: addr=DST_BASE+2i+1, wr_en=1. Then i++ → RD_LO, or → DONE if i=NUM_MSG-1.
- IDLE/DONE + start=1 → RD_LO next cycle; counters and i cleared; done drops.
- done rises exactly 5·NUM_MSG+1 cycles after the start-sampling edge (76 for defaults).
- start while busy: ignored.
- reset mid-run: state → IDLE next edge, wr_en=0 that cycle. Bytes already written stay in memory.
- mem_wr_en is never high outside WR_LO/WR_HI.
- Counters saturate at 15.
- Address arithmetic wraps modulo 2^AW.
- Source and destination regions may not overlap; behaviour is undefined if they do.

Test Plan:
- Preload 0x0000 at 30/31, pulse start → bytes 0,1 = 0x00,0x00; single_cnt=0, double_cnt=0.
- Word 0xFFFF (data 0x7FF, all parity 1) → low 0xFF, high 0x07, F=00.
- Word 0x0008 (d1 flipped on zero message) → s=3 corrected; low 0x00, high 0x40; single_cnt=1.
- Word 0x0001 (p0 only) → low 0x00, high 0x40. Word 0xFFF9 (bits 1,2 flipped) → low 0xFF, high 0x87; double_cnt=1.
- 15 random encoded messages, mixed 0/1/2 flips (75% one, ~25% two) → all 30 output bytes match the reference model; done at cycle 76; second start pulse during run has no effect.
- Assert reset at cycle 20 of a run → done=0, busy=0, wr_en=0 next edge. New start → full correct run from message 0, counters restart at 0.
